// File: rtl/pipe_hazard_ctrl_if.sv
// ---------------------------------------------------------------------------
// pipe_hazard_ctrl_if
//
// Purpose: bundles the signals exchanged between the 5-stage pipeline datapath
// and the hazard controller.
//
// Signal summary (direction as seen by the hazard controller):
//   id_rs, id_rt        in  [4:0] source registers of the instruction in ID
//   id_uses_rt          in        ID instruction actually reads rt
//   ex_rd               in  [4:0] destination of the instruction in EX
//   ex_regwrite         in        EX instruction writes the register file
//   ex_memread          in        EX instruction is a load
//   mem_rd              in  [4:0] destination of the instruction in MEM
//   mem_regwrite        in        MEM instruction writes the register file
//   mem_memread         in        MEM instruction reads data memory
//   mem_memwrite        in        MEM instruction writes data memory
//   dmem_ready          in        data memory completes the MEM access now
//   ex_branch_taken     in        branch in EX resolved taken
//   pc_en               out       PC write enable
//   en_if2id..en_mem2wb out       pipeline register write enables
//   flush_if2id         out       synchronous clear of IF/ID
//   flush_id2ex         out       synchronous clear of ID/EX (bubble insert)
//   stall_cycles        out [15:0] saturating count of cycles with pc_en low
//   mem_timeout         out       sticky memory-wait watchdog flag
//
// Modports: master = pipeline datapath side, slave = hazard controller.
// ---------------------------------------------------------------------------
interface pipe_hazard_ctrl_if;
  logic [4:0]  id_rs;
  logic [4:0]  id_rt;
  logic        id_uses_rt;
  logic [4:0]  ex_rd;
  logic        ex_regwrite;
  logic        ex_memread;
  logic [4:0]  mem_rd;
  logic        mem_regwrite;
  logic        mem_memread;
  logic        mem_memwrite;
  logic        dmem_ready;
  logic        ex_branch_taken;

  logic        pc_en;
  logic        en_if2id;
  logic        en_id2ex;
  logic        en_ex2mem;
  logic        en_mem2wb;
  logic        flush_if2id;
  logic        flush_id2ex;
  logic [15:0] stall_cycles;
  logic        mem_timeout;

  modport master (
    output id_rs, id_rt, id_uses_rt,
    output ex_rd, ex_regwrite, ex_memread,
    output mem_rd, mem_regwrite, mem_memread, mem_memwrite,
    output dmem_ready, ex_branch_taken,
    input  pc_en, en_if2id, en_id2ex, en_ex2mem, en_mem2wb,
    input  flush_if2id, flush_id2ex, stall_cycles, mem_timeout
  );

  modport slave (
    input  id_rs, id_rt, id_uses_rt,
    input  ex_rd, ex_regwrite, ex_memread,
    input  mem_rd, mem_regwrite, mem_memread, mem_memwrite,
    input  dmem_ready, ex_branch_taken,
    output pc_en, en_if2id, en_id2ex, en_ex2mem, en_mem2wb,
    output flush_if2id, flush_id2ex, stall_cycles, mem_timeout
  );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// pipe_hazard_ctrl
//
// Purpose: stall / flush controller for a classic 5-stage pipeline. Decides
// each cycle whether the pipeline freezes (data memory busy), squashes the
// wrong-path instructions (taken branch), inserts one bubble (RAW hazard),
// or runs normally. Also tracks how long the data memory has been waiting
// and raises a sticky watchdog flag after a very long wait.
//
// Ports:
//   clk  in   pipeline clock, rising edge
//   rst  in   synchronous, active-high reset
//   hz   slave modport of pipe_hazard_ctrl_if (all pipeline-facing signals)
//
// Build option:
//   FWD_EN  defined   -> datapath forwards ALU results, only load-use stalls.
//           undefined -> no forwarding: any RAW against EX or MEM stalls.
//
// The enable/flush outputs are purely combinational from the current inputs
// so the datapath sees them in the same cycle; the FSM only measures how long
// a memory access has been outstanding.
// ---------------------------------------------------------------------------
module pipe_hazard_ctrl (
  input  logic               clk,
  input  logic               rst,
  pipe_hazard_ctrl_if.slave  hz
);

  typedef enum logic {
    RUN     = 1'b0,
    MEMWAIT = 1'b1
  } state_e;

  state_e      state_q;
  logic [7:0]  wait_q;
  logic        timeout_q;
  logic [15:0] stall_q, stall_d;

  logic mem_stall;
  logic load_use;
  logic hazard;

  // Data memory access that has not completed freezes the whole pipe.
  assign mem_stall = (hz.mem_memread | hz.mem_memwrite) & ~hz.dmem_ready;

  // Load in EX whose result the ID instruction needs; r0 is hardwired zero
  // and can never carry a dependency.
  assign load_use = hz.ex_memread && (hz.ex_rd != 5'd0) &&
                    ((hz.ex_rd == hz.id_rs) ||
                     (hz.id_uses_rt && (hz.ex_rd == hz.id_rt)));

`ifdef FWD_EN
  // Forwarding resolves every other RAW, so only the load-use case remains.
  assign hazard = load_use;

  // Destination/write info of the later stages is not needed here.
  logic unused_raw;
  assign unused_raw = ^{hz.ex_regwrite, hz.mem_rd, hz.mem_regwrite};
`else
  logic ex_raw, mem_raw;

  // Without forwarding the ID instruction must wait until every older
  // producer has left MEM. The bubble repeats each cycle until this clears.
  assign ex_raw  = hz.ex_regwrite && (hz.ex_rd != 5'd0) &&
                   ((hz.ex_rd == hz.id_rs) ||
                    (hz.id_uses_rt && (hz.ex_rd == hz.id_rt)));
  assign mem_raw = hz.mem_regwrite && (hz.mem_rd != 5'd0) &&
                   ((hz.mem_rd == hz.id_rs) ||
                    (hz.id_uses_rt && (hz.mem_rd == hz.id_rt)));
  assign hazard  = load_use | ex_raw | mem_raw;
`endif

  // Priority: reset > memory freeze > taken branch > RAW bubble > run.
  always_comb begin
    hz.pc_en       = 1'b1;
    hz.en_if2id    = 1'b1;
    hz.en_id2ex    = 1'b1;
    hz.en_ex2mem   = 1'b1;
    hz.en_mem2wb   = 1'b1;
    hz.flush_if2id = 1'b0;
    hz.flush_id2ex = 1'b0;
    if (rst) begin
      // Hold everything and clear the front registers while in reset.
      hz.pc_en       = 1'b0;
      hz.en_if2id    = 1'b0;
      hz.en_id2ex    = 1'b0;
      hz.en_ex2mem   = 1'b0;
      hz.en_mem2wb   = 1'b0;
      hz.flush_if2id = 1'b1;
      hz.flush_id2ex = 1'b1;
    end else if (mem_stall) begin
      // Full freeze; flushing now would destroy state we must resume with.
      hz.pc_en       = 1'b0;
      hz.en_if2id    = 1'b0;
      hz.en_id2ex    = 1'b0;
      hz.en_ex2mem   = 1'b0;
      hz.en_mem2wb   = 1'b0;
    end else if (hz.ex_branch_taken) begin
      // Squash the two wrong-path instructions; any hazard they had is moot.
      hz.flush_if2id = 1'b1;
      hz.flush_id2ex = 1'b1;
    end else if (hazard) begin
      // Hold PC and IF/ID, push a bubble into EX, let older work drain.
      hz.pc_en       = 1'b0;
      hz.en_if2id    = 1'b0;
      hz.flush_id2ex = 1'b1;
    end
  end

  // Memory-wait FSM with its wait counter and sticky watchdog flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= RUN;
      wait_q    <= 8'd0;
      timeout_q <= 1'b0;
    end else begin
      case (state_q)
        RUN: begin
          if (mem_stall) begin
            state_q <= MEMWAIT;
            wait_q  <= 8'd0;
          end
        end
        MEMWAIT: begin
          if (wait_q == 8'hFF) timeout_q <= 1'b1;
          if (hz.dmem_ready) begin
            state_q <= RUN;
          end else if (wait_q != 8'hFF) begin
            wait_q <= wait_q + 8'd1;
          end
        end
        default: begin
          state_q <= RUN;
          wait_q  <= 8'd0;
        end
      endcase
    end
  end

  // Saturating stalled-cycle counter (any cycle the PC does not advance).
  always_comb begin
    stall_d = stall_q;
    if (!hz.pc_en && (stall_q != 16'hFFFF)) stall_d = stall_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) stall_q <= 16'd0;
    else     stall_q <= stall_d;
  end

  assign hz.stall_cycles = stall_q;
  assign hz.mem_timeout  = timeout_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
module tb_pipe_hazard_ctrl;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pipe_hazard_ctrl_if hz();
  pipe_hazard_ctrl dut (.clk(clk), .rst(rst), .hz(hz.slave));

  int checks = 0;
  int errors = 0;

  typedef struct {
    string      name;
    logic [4:0] id_rs, id_rt;
    logic       id_uses_rt;
    logic [4:0] ex_rd;
    logic       ex_regwrite, ex_memread;
    logic [4:0] mem_rd;
    logic       mem_regwrite, mem_memread, mem_memwrite;
    logic       dmem_ready, ex_branch_taken;
    // {pc_en, en_if2id, en_id2ex, en_ex2mem, en_mem2wb, flush_if2id, flush_id2ex}
    logic [6:0] exp;
  } vec_t;

  localparam logic [6:0] RUNV   = 7'b1111100;
  localparam logic [6:0] BUBBLE = 7'b0011101;
  localparam logic [6:0] FREEZE = 7'b0000000;
  localparam logic [6:0] BRANCH = 7'b1111111;
  localparam logic [6:0] RESETV = 7'b0000011;
`ifdef FWD_EN
  localparam logic [6:0] RAWEXP = RUNV;
`else
  localparam logic [6:0] RAWEXP = BUBBLE;
`endif

  vec_t vecs[12];

  function automatic logic [6:0] outs();
    return {hz.pc_en, hz.en_if2id, hz.en_id2ex, hz.en_ex2mem, hz.en_mem2wb,
            hz.flush_if2id, hz.flush_id2ex};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    hz.id_rs = v.id_rs; hz.id_rt = v.id_rt; hz.id_uses_rt = v.id_uses_rt;
    hz.ex_rd = v.ex_rd; hz.ex_regwrite = v.ex_regwrite; hz.ex_memread = v.ex_memread;
    hz.mem_rd = v.mem_rd; hz.mem_regwrite = v.mem_regwrite;
    hz.mem_memread = v.mem_memread; hz.mem_memwrite = v.mem_memwrite;
    hz.dmem_ready = v.dmem_ready; hz.ex_branch_taken = v.ex_branch_taken;
  endtask

  function automatic vec_t mk(string n, logic [4:0] rs, logic [4:0] rt, logic urt,
                              logic [4:0] erd, logic erw, logic emr,
                              logic [4:0] mrd, logic mrw, logic mmr, logic mmw,
                              logic rdy, logic br, logic [6:0] e);
    vec_t v;
    v.name = n; v.id_rs = rs; v.id_rt = rt; v.id_uses_rt = urt;
    v.ex_rd = erd; v.ex_regwrite = erw; v.ex_memread = emr;
    v.mem_rd = mrd; v.mem_regwrite = mrw; v.mem_memread = mmr; v.mem_memwrite = mmw;
    v.dmem_ready = rdy; v.ex_branch_taken = br; v.exp = e;
    return v;
  endfunction

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic idle();
    drive(mk("idle", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, RUNV));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cyc(); cyc();
    rst = 1'b0;
  endtask

  initial begin
    //                 name          rs  rt urt erd erw emr mrd mrw mmr mmw rdy br  exp
    vecs[0]  = mk("idle",            0,  0, 0,  0, 0,  0,  0,  0,  0,  0,  1,  0, RUNV);
    vecs[1]  = mk("loaduse_rs",      5,  1, 0,  5, 1,  1,  0,  0,  0,  0,  1,  0, BUBBLE);
    vecs[2]  = mk("loaduse_rt",      3,  9, 1,  9, 1,  1,  0,  0,  0,  0,  1,  0, BUBBLE);
    vecs[3]  = mk("load_rt_unused",  3,  9, 0,  9, 0,  1,  0,  0,  0,  0,  1,  0, RUNV);
    vecs[4]  = mk("load_rd_zero",    0,  0, 1,  0, 1,  1,  0,  0,  0,  0,  1,  0, RUNV);
    vecs[5]  = mk("branch_hazard",   5,  0, 0,  5, 1,  1,  0,  0,  0,  0,  1,  1, BRANCH);
    vecs[6]  = mk("branch_memstall", 5,  0, 0,  5, 1,  1,  0,  0,  1,  0,  0,  1, FREEZE);
    vecs[7]  = mk("memwrite_stall",  0,  0, 0,  0, 0,  0,  0,  0,  0,  1,  0,  0, FREEZE);
    vecs[8]  = mk("memread_ready",   0,  0, 0,  0, 0,  0,  0,  0,  1,  0,  1,  0, RUNV);
    vecs[9]  = mk("alu_raw_ex_rt",   2,  7, 1,  7, 1,  0,  0,  0,  0,  0,  1,  0, RAWEXP);
    vecs[10] = mk("alu_raw_mem_rs", 12,  0, 0,  0, 0,  0, 12,  1,  0,  0,  1,  0, RAWEXP);
    vecs[11] = mk("mem_rd_zero",     0,  0, 0,  0, 0,  0,  0,  1,  0,  0,  1,  0, RUNV);

    // Reset: outputs forced regardless of a hazard on the inputs.
    drive(vecs[1]);
    rst = 1'b1;
    cyc();
    chk("reset_outputs", 32'(outs()), 32'(RESETV));
    cyc();
    chk("reset_stall_cycles", 32'(hz.stall_cycles), 32'd0);
    chk("reset_timeout", 32'(hz.mem_timeout), 32'd0);
    rst = 1'b0;
    idle();

    // Table of single-cycle combinational cases.
    cyc();
    for (int i = 0; i < 12; i++) begin
      drive(vecs[i]);
      #1;
      chk(vecs[i].name, 32'(outs()), 32'(vecs[i].exp));
      cyc();
    end

    // Load-use: exactly one stalled cycle counted.
    do_reset();
    drive(vecs[1]);
    #1;
    chk("lu_outputs", 32'(outs()), 32'(BUBBLE));
    cyc();
    idle();
    #1;
    chk("lu_after", 32'(outs()), 32'(RUNV));
    chk("lu_stall_cycles", 32'(hz.stall_cycles), 32'd1);

    // Memory wait: three frozen cycles, then release.
    do_reset();
    drive(vecs[8]);
    hz.dmem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("memwait_freeze", 32'(outs()), 32'(FREEZE));
      cyc();
    end
    hz.dmem_ready = 1'b1;
    #1;
    chk("memwait_release", 32'(outs()), 32'(RUNV));
    chk("memwait_stall_cycles", 32'(hz.stall_cycles), 32'd3);
    cyc();
    idle();

    // Memory ready arrives together with a taken branch in EX.
    do_reset();
    drive(vecs[6]);
    cyc(); cyc();
    hz.dmem_ready = 1'b1;
    #1;
    chk("ready_with_branch", 32'(outs()), 32'(BRANCH));
    cyc();
    idle();
    #1;
    chk("ready_branch_stalls", 32'(hz.stall_cycles), 32'd2);

    // Watchdog: 300 cycles of unready memory.
    do_reset();
    drive(vecs[8]);
    hz.dmem_ready = 1'b0;
    for (int i = 1; i <= 300; i++) begin
      cyc();
      if (i == 250) chk("wd_not_yet", 32'(hz.mem_timeout), 32'd0);
    end
    chk("wd_fired", 32'(hz.mem_timeout), 32'd1);
    chk("wd_stall_cycles", 32'(hz.stall_cycles), 32'd300);
    idle();
    for (int i = 0; i < 5; i++) cyc();
    chk("wd_sticky", 32'(hz.mem_timeout), 32'd1);
    // Reset in the middle of a wait aborts it and clears the flag.
    drive(vecs[8]);
    hz.dmem_ready = 1'b0;
    cyc();
    rst = 1'b1;
    idle();
    cyc();
    rst = 1'b0;
    #1;
    chk("wd_cleared", 32'(hz.mem_timeout), 32'd0);
    chk("post_reset_run", 32'(outs()), 32'(RUNV));
    cyc();
    chk("post_reset_stalls", 32'(hz.stall_cycles), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
